// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit.
//   - DEFAULT_AW / DEFAULT_CW : default PC width and performance-counter width
//   - bru_state_e             : resolve FSM encoding (ST_IDLE = 0, ST_REDIRECT = 1)
package branch_resolve_unit_pkg;

  localparam int DEFAULT_AW = 32;
  localparam int DEFAULT_CW = 16;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } bru_state_e;

endpackage

// File: rtl/branch_resolve_unit_sat_counter.sv
// Saturating up-counter used for the branch performance counters.
//   clock : rising-edge clock
//   reset : synchronous active-high reset, clears the count
//   inc   : increment request for this cycle
//   count : current count; sticks at all-ones instead of wrapping
module sat_counter
  import branch_resolve_unit_pkg::*;
#(
  parameter int W = DEFAULT_CW
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: carries the ID-stage prediction of a conditional branch
// into EX, compares it against the actual outcome, and on a mispredict flushes
// the wrong-path IF/ID and ID/EX slots and redirects fetch to the correct PC.
// Also emits a registered resolve event for predictor training and keeps
// saturating counters of resolved and mispredicted branches.
//
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   BranchExists_ID       : a conditional branch is in ID this cycle
//   Prediction_ID         : predicted direction (1 = taken)
//   PCPlus4_ID            : fall-through address of the ID branch
//   BranchTarget_ID       : taken target of the ID branch
//   Stall                 : hazard stall; holds the ID/EX slot and defers resolution
//   BranchDecision_EX     : actual outcome of the EX branch (meaningful when slot valid)
//   Redirect_Valid / _PC  : registered 1-cycle redirect pulse and its target PC
//   Flush                 : registered 1-cycle squash of IF/ID and ID/EX
//   Resolve_Valid / _Taken: registered 1-cycle resolve event and actual direction
//   BranchCount           : saturating count of resolved branches
//   MispredictCount       : saturating count of mispredicted branches
//   dbg_state             : current FSM state (ST_IDLE / ST_REDIRECT)
//
// Handshake: there is no back-pressure. Resolve_Valid, Flush and Redirect_Valid
// are single-cycle pulses that consumers must accept in the cycle they are high;
// Redirect_PC and Resolve_Taken are only meaningful alongside their pulse.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int AW = DEFAULT_AW,
  parameter int CW = DEFAULT_CW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          BranchExists_ID,
  input  logic          Prediction_ID,
  input  logic [AW-1:0] PCPlus4_ID,
  input  logic [AW-1:0] BranchTarget_ID,
  input  logic          Stall,
  input  logic          BranchDecision_EX,
  output logic          Redirect_Valid,
  output logic [AW-1:0] Redirect_PC,
  output logic          Flush,
  output logic          Resolve_Valid,
  output logic          Resolve_Taken,
  output logic [CW-1:0] BranchCount,
  output logic [CW-1:0] MispredictCount,
  output logic          dbg_state
);

  bru_state_e    state_q, state_d;

  // ID/EX slot
  logic          ex_valid_q, ex_valid_d;
  logic          ex_pred_q, ex_pred_d;
  logic [AW-1:0] ex_pc4_q, ex_pc4_d;
  logic [AW-1:0] ex_tgt_q, ex_tgt_d;

  // Output registers
  logic          redirect_valid_q, redirect_valid_d;
  logic [AW-1:0] redirect_pc_q, redirect_pc_d;
  logic          flush_q, flush_d;
  logic          resolve_valid_q, resolve_valid_d;
  logic          resolve_taken_q, resolve_taken_d;

  logic          resolve;
  logic          mispredict;

  // A branch resolves only once it is no longer held by a stall and the
  // pipeline is not in the middle of a redirect.
  assign resolve    = ex_valid_q & ~Stall & (state_q == ST_IDLE);
  assign mispredict = resolve & (BranchDecision_EX != ex_pred_q);

  always_comb begin
    state_d          = state_q;
    ex_valid_d       = ex_valid_q;
    ex_pred_d        = ex_pred_q;
    ex_pc4_d         = ex_pc4_q;
    ex_tgt_d         = ex_tgt_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = 1'b0;
    resolve_valid_d  = 1'b0;
    resolve_taken_d  = resolve_taken_q;

    // ID/EX slot: the branch sitting in ID during a redirect is wrong-path.
    if (state_q == ST_REDIRECT) begin
      ex_valid_d = 1'b0;
    end else if (!Stall) begin
      ex_valid_d = BranchExists_ID;
      ex_pred_d  = Prediction_ID;
      ex_pc4_d   = PCPlus4_ID;
      ex_tgt_d   = BranchTarget_ID;
    end

    if (resolve) begin
      resolve_valid_d = 1'b1;
      resolve_taken_d = BranchDecision_EX;
    end

    if (mispredict) begin
      flush_d          = 1'b1;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = BranchDecision_EX ? ex_tgt_q : ex_pc4_q;
      // The ID branch captured on this edge is wrong-path; kill it.
      ex_valid_d       = 1'b0;
    end

    // The redirect state lasts exactly one cycle regardless of Stall.
    if (state_q == ST_IDLE) begin
      if (mispredict) begin
        state_d = ST_REDIRECT;
      end
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      ex_valid_q       <= 1'b0;
      ex_pred_q        <= 1'b0;
      ex_pc4_q         <= '0;
      ex_tgt_q         <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      resolve_valid_q  <= 1'b0;
      resolve_taken_q  <= 1'b0;
    end else begin
      state_q          <= state_d;
      ex_valid_q       <= ex_valid_d;
      ex_pred_q        <= ex_pred_d;
      ex_pc4_q         <= ex_pc4_d;
      ex_tgt_q         <= ex_tgt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      resolve_valid_q  <= resolve_valid_d;
      resolve_taken_q  <= resolve_taken_d;
    end
  end

  sat_counter #(.W(CW)) u_branch_count (
    .clock (clock),
    .reset (reset),
    .inc   (resolve),
    .count (BranchCount)
  );

  sat_counter #(.W(CW)) u_mispredict_count (
    .clock (clock),
    .reset (reset),
    .inc   (mispredict),
    .count (MispredictCount)
  );

  assign Redirect_Valid = redirect_valid_q;
  assign Redirect_PC    = redirect_pc_q;
  assign Flush          = flush_q;
  assign Resolve_Valid  = resolve_valid_q;
  assign Resolve_Taken  = resolve_taken_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  localparam int AW   = 32;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          clock;
  logic          reset;
  logic          BranchExists_ID;
  logic          Prediction_ID;
  logic [AW-1:0] PCPlus4_ID;
  logic [AW-1:0] BranchTarget_ID;
  logic          Stall;
  logic          BranchDecision_EX;
  logic          Redirect_Valid;
  logic [AW-1:0] Redirect_PC;
  logic          Flush;
  logic          Resolve_Valid;
  logic          Resolve_Taken;
  logic [CW-1:0] BranchCount;
  logic [CW-1:0] MispredictCount;
  logic          dbg_state;

  branch_resolve_unit #(.AW(AW), .CW(CW)) dut (
    .clock             (clock),
    .reset             (reset),
    .BranchExists_ID   (BranchExists_ID),
    .Prediction_ID     (Prediction_ID),
    .PCPlus4_ID        (PCPlus4_ID),
    .BranchTarget_ID   (BranchTarget_ID),
    .Stall             (Stall),
    .BranchDecision_EX (BranchDecision_EX),
    .Redirect_Valid    (Redirect_Valid),
    .Redirect_PC       (Redirect_PC),
    .Flush             (Flush),
    .Resolve_Valid     (Resolve_Valid),
    .Resolve_Taken     (Resolve_Taken),
    .BranchCount       (BranchCount),
    .MispredictCount   (MispredictCount),
    .dbg_state         (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  // entry: {mispredict, taken, redirect_pc}
  logic [AW+1:0] exp_q[$];
  logic [AW+1:0] mon_e;
  int model_bc = 0;
  int model_mc = 0;
  bit mon_en   = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: samples on the falling edge, pops one expectation per resolve.
  always @(negedge clock) begin
    if (mon_en) begin
      if (Resolve_Valid) begin
        check("resolve_expected", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("resolve_taken", Resolve_Taken, mon_e[AW]);
          check("flush", Flush, mon_e[AW+1]);
          check("redirect_valid", Redirect_Valid, mon_e[AW+1]);
          if (mon_e[AW+1]) check("redirect_pc", Redirect_PC, mon_e[AW-1:0]);
          if (model_bc < CMAX) model_bc++;
          if (mon_e[AW+1] && model_mc < CMAX) model_mc++;
        end
      end else begin
        check("flush_idle", Flush, 0);
        check("redirect_idle", Redirect_Valid, 0);
      end
      check("branch_count", BranchCount, model_bc);
      check("mispredict_count", MispredictCount, model_mc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_wrong_path();
    BranchExists_ID = 1'b1;
    Prediction_ID   = 1'($urandom_range(0, 1));
    PCPlus4_ID      = $urandom;
    BranchTarget_ID = $urandom;
  endtask

  // One branch through ID then EX; on a mispredict, wrong-path branches are
  // presented in ID for the two following cycles and must never resolve.
  task automatic run_branch(input logic pred, input logic [AW-1:0] pc4,
                            input logic [AW-1:0] tgt, input logic dec);
    logic mis;
    mis = (pred != dec);
    BranchExists_ID = 1'b1;
    Prediction_ID   = pred;
    PCPlus4_ID      = pc4;
    BranchTarget_ID = tgt;
    tick();
    BranchDecision_EX = dec;
    exp_q.push_back({mis, dec, (dec ? tgt : pc4)});
    if (mis) drive_wrong_path();
    else     BranchExists_ID = 1'b0;
    tick();
    if (mis) drive_wrong_path();
    else     BranchExists_ID = 1'b0;
    BranchDecision_EX = 1'($urandom_range(0, 1));
    tick();
    BranchExists_ID = 1'b0;
    tick();
  endtask

  logic b2b_dec[8];

  initial begin
    reset             = 1'b1;
    BranchExists_ID   = 1'b0;
    Prediction_ID     = 1'b0;
    PCPlus4_ID        = '0;
    BranchTarget_ID   = '0;
    Stall             = 1'b0;
    BranchDecision_EX = 1'b0;

    // 1. reset
    tick();
    tick();
    check("rst_resolve_valid", Resolve_Valid, 0);
    check("rst_resolve_taken", Resolve_Taken, 0);
    check("rst_flush", Flush, 0);
    check("rst_redirect_valid", Redirect_Valid, 0);
    check("rst_redirect_pc", Redirect_PC, 0);
    check("rst_branch_count", BranchCount, 0);
    check("rst_mispredict_count", MispredictCount, 0);
    check("rst_state", dbg_state, ST_IDLE);
    reset = 1'b0;
    tick();
    tick();
    check("idle_resolve_valid", Resolve_Valid, 0);
    check("idle_flush", Flush, 0);
    mon_en = 1'b1;

    // 2. correct taken prediction
    run_branch(1'b1, 32'h44, 32'h100, 1'b1);
    check("t2_branch_count", BranchCount, 1);

    // 3. mispredict, actually taken
    run_branch(1'b0, 32'h84, 32'h200, 1'b1);
    check("t3_mispredict_count", MispredictCount, 1);
    check("t3_redirect_pc_hold", Redirect_PC, 32'h200);

    // 4. mispredict, actually not taken
    run_branch(1'b1, 32'h84, 32'h300, 1'b0);
    check("t4_redirect_pc_hold", Redirect_PC, 32'h84);

    // 5. stall with a valid EX branch; a different branch waits in ID
    BranchExists_ID = 1'b1;
    Prediction_ID   = 1'b1;
    PCPlus4_ID      = 32'h504;
    BranchTarget_ID = 32'h600;
    tick();
    Stall             = 1'b1;
    BranchDecision_EX = 1'b1;
    Prediction_ID     = 1'b0;
    PCPlus4_ID        = 32'h704;
    BranchTarget_ID   = 32'h800;
    exp_q.push_back({1'b0, 1'b1, 32'h600});
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_no_resolve", Resolve_Valid, 0);
    end
    Stall           = 1'b0;
    BranchExists_ID = 1'b0;
    tick();
    check("stall_release_resolve", Resolve_Valid, 1);
    tick();
    check("stall_single_pulse", Resolve_Valid, 0);
    tick();

    // back-to-back correctly predicted branches
    for (int i = 0; i < 6; i++) b2b_dec[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) begin
        BranchExists_ID = 1'b1;
        Prediction_ID   = b2b_dec[i];
        PCPlus4_ID      = 32'h1000 + 32'(i * 8);
        BranchTarget_ID = 32'h2000 + 32'(i * 8);
      end else begin
        BranchExists_ID = 1'b0;
      end
      if (i > 0) begin
        BranchDecision_EX = b2b_dec[i-1];
        exp_q.push_back({1'b0, b2b_dec[i-1], 32'h0});
      end
      tick();
      if (i > 0) check("b2b_resolve_valid", Resolve_Valid, 1);
    end
    tick();
    tick();

    // 6. saturate both counters with mispredicts
    for (int i = 0; i < 20; i++) begin
      logic d;
      d = 1'($urandom_range(0, 1));
      run_branch(~d, $urandom, $urandom, d);
    end
    check("sat_branch_count", BranchCount, CMAX);
    check("sat_mispredict_count", MispredictCount, CMAX);

    // reset while in REDIRECT
    BranchExists_ID = 1'b1;
    Prediction_ID   = 1'b0;
    PCPlus4_ID      = 32'h904;
    BranchTarget_ID = 32'hA00;
    tick();
    BranchDecision_EX = 1'b1;
    BranchExists_ID   = 1'b0;
    exp_q.push_back({1'b1, 1'b1, 32'hA00});
    tick();
    check("pre_rst_state", dbg_state, ST_REDIRECT);
    check("pre_rst_flush", Flush, 1);
    reset = 1'b1;
    @(negedge clock);
    #1;
    mon_en = 1'b0;
    tick();
    check("mid_rst_resolve_valid", Resolve_Valid, 0);
    check("mid_rst_flush", Flush, 0);
    check("mid_rst_redirect_valid", Redirect_Valid, 0);
    check("mid_rst_redirect_pc", Redirect_PC, 0);
    check("mid_rst_branch_count", BranchCount, 0);
    check("mid_rst_mispredict_count", MispredictCount, 0);
    check("mid_rst_state", dbg_state, ST_IDLE);
    model_bc = 0;
    model_mc = 0;
    reset = 1'b0;
    tick();
    mon_en = 1'b1;
    run_branch(1'b0, 32'h44, 32'h48, 1'b0);
    tick();

    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
